// File: rtl/alu_pkg.sv
// Shared types for the execute-stage ALU: request op classes, decoded control codes,
// FSM states and the divide special-case classes.
package alu_pkg;

  // Controller request class
  typedef enum logic [1:0] {
    AluOpAdd     = 2'b00,
    AluOpSub     = 2'b01,
    AluOpFunct   = 2'b10,
    AluOpIllegal = 2'b11
  } alu_op_e;

  // Decoded operation. Div/Rem signedness travels alongside as a separate flag.
  typedef enum logic [3:0] {
    CtrlAdd, CtrlSub, CtrlSll, CtrlSlt, CtrlSltu, CtrlXor, CtrlSrl, CtrlSra,
    CtrlOr, CtrlAnd, CtrlMul, CtrlMulh, CtrlMulhsu, CtrlMulhu, CtrlDiv, CtrlRem
  } alu_ctrl_e;

  typedef enum logic [2:0] {
    StIdle, StExec, StMul, StDiv, StDone
  } exec_state_e;

  // Divide outcomes that bypass the iterative engine
  typedef enum logic [1:0] {
    DivNormal, DivByZero, DivOverflow, DivEarly
  } div_case_e;

  function automatic logic is_mul_op(input alu_ctrl_e c);
    return c inside {CtrlMul, CtrlMulh, CtrlMulhsu, CtrlMulhu};
  endfunction

  function automatic logic is_div_op(input alu_ctrl_e c);
    return c inside {CtrlDiv, CtrlRem};
  endfunction

endpackage

// File: rtl/alu_ctrl_decode.sv
// Combinational ALU control decode: request class + instruction fields -> control code.
module alu_ctrl_decode
  import alu_pkg::*;
(
  input  logic [1:0] i_alu_op,
  input  logic [2:0] i_funct3,
  input  logic       i_op_5,
  input  logic       i_funct7_5,
  input  logic       i_funct7_0,
  output alu_ctrl_e  o_ctrl,
  output logic       o_div_uns,
  output logic       o_illegal
);

  // Map request fields onto a control code; M ops only exist on R-type
  always_comb begin
    o_ctrl    = CtrlAdd;
    o_div_uns = 1'b0;
    o_illegal = 1'b0;
    unique case (alu_op_e'(i_alu_op))
      AluOpAdd:     o_ctrl = CtrlAdd;
      AluOpSub:     o_ctrl = CtrlSub;
      AluOpIllegal: o_illegal = 1'b1;
      AluOpFunct: begin
        if (i_op_5 && i_funct7_0) begin
          o_div_uns = i_funct3[0];
          unique case (i_funct3)
            3'b000:          o_ctrl = CtrlMul;
            3'b001:          o_ctrl = CtrlMulh;
            3'b010:          o_ctrl = CtrlMulhsu;
            3'b011:          o_ctrl = CtrlMulhu;
            3'b100, 3'b101:  o_ctrl = CtrlDiv;
            default:         o_ctrl = CtrlRem;
          endcase
        end else begin
          unique case (i_funct3)
            3'b000:  o_ctrl = (i_op_5 && i_funct7_5) ? CtrlSub : CtrlAdd;
            3'b001:  o_ctrl = CtrlSll;
            3'b010:  o_ctrl = CtrlSlt;
            3'b011:  o_ctrl = CtrlSltu;
            3'b100:  o_ctrl = CtrlXor;
            3'b101:  o_ctrl = i_funct7_5 ? CtrlSra : CtrlSrl;
            3'b110:  o_ctrl = CtrlOr;
            default: o_ctrl = CtrlAnd;
          endcase
        end
      end
      default: o_illegal = 1'b1;
    endcase
  end

endmodule

// File: rtl/alu_exec_unit.sv
// Execute-stage ALU: single-cycle base ops, iterative 1-bit/cycle mul/div engine,
// valid/ready on both sides. Define ALU_EARLY_OUT_EN to finish trivial mul/div in 1 cycle.
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      alu_op,
  input  logic [2:0]      funct3,
  input  logic            op_5,
  input  logic            funct7_5,
  input  logic            funct7_0,
  input  logic [XLEN-1:0] src_a,
  input  logic [XLEN-1:0] src_b,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            illegal
);

  localparam int unsigned CNT_W = $clog2(XLEN) + 1;
  localparam int unsigned SH_W  = $clog2(XLEN);
  localparam logic [XLEN-1:0] MinVal = {1'b1, {(XLEN-1){1'b0}}};

  exec_state_e       r_state, w_state_next, w_in_state;
  logic              r_init;
  logic [XLEN-1:0]   r_a, r_b, r_mag;
  logic [2*XLEN-1:0] r_acc;
  logic [CNT_W-1:0]  r_cnt;
  alu_ctrl_e         r_ctrl;
  logic              r_div_uns, r_op_illegal, r_a_signed, r_b_signed;
  logic [XLEN-1:0]   r_result;
  logic              r_zero, r_illegal;

  alu_ctrl_e         w_dec_ctrl;
  logic              w_dec_div_uns, w_dec_illegal;
  logic              w_accept, w_a_signed, w_b_signed, w_in_mul_early;
  div_case_e         w_in_div_case, w_div_case;
  logic [XLEN-1:0]   w_exec_res, w_fin_res, w_quo, w_rem, w_div_sub;
  logic [SH_W-1:0]   w_shamt;
  logic [XLEN:0]     w_mul_sum, w_rem_sh;
  logic [2*XLEN-1:0] w_mul_next, w_div_next, w_prod;
  logic              w_div_ge, w_neg, w_iter_done;

  function automatic logic [XLEN-1:0] f_mag(input logic [XLEN-1:0] v, input logic s);
    return (s && v[XLEN-1]) ? (~v + 1'b1) : v;
  endfunction

  function automatic div_case_e f_div_case(input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                                           input logic uns);
    div_case_e c;
    c = DivNormal;
    if (b == '0) c = DivByZero;
    else if (!uns && (a == MinVal) && (b == '1)) c = DivOverflow;
`ifdef ALU_EARLY_OUT_EN
    else if (f_mag(a, !uns) < f_mag(b, !uns)) c = DivEarly;
`endif
    return c;
  endfunction

  alu_ctrl_decode u_ctrl_decode (
    .i_alu_op   (alu_op),
    .i_funct3   (funct3),
    .i_op_5     (op_5),
    .i_funct7_5 (funct7_5),
    .i_funct7_0 (funct7_0),
    .o_ctrl     (w_dec_ctrl),
    .o_div_uns  (w_dec_div_uns),
    .o_illegal  (w_dec_illegal)
  );

  assign w_accept   = in_valid && in_ready;
  assign w_a_signed = (w_dec_ctrl inside {CtrlMul, CtrlMulh, CtrlMulhsu}) ||
                      (is_div_op(w_dec_ctrl) && !w_dec_div_uns);
  assign w_b_signed = (w_dec_ctrl inside {CtrlMul, CtrlMulh}) ||
                      (is_div_op(w_dec_ctrl) && !w_dec_div_uns);
  assign w_in_div_case = f_div_case(src_a, src_b, w_dec_div_uns);

`ifdef ALU_EARLY_OUT_EN
  assign w_in_mul_early = (src_a == '0) || (src_b == '0);
`else
  assign w_in_mul_early = 1'b0;
`endif

  // Route an accepted op to the engine only when no fast path applies
  always_comb begin
    w_in_state = StExec;
    if (!w_dec_illegal && is_mul_op(w_dec_ctrl) && !w_in_mul_early) w_in_state = StMul;
    if (!w_dec_illegal && is_div_op(w_dec_ctrl) && (w_in_div_case == DivNormal)) begin
      w_in_state = StDiv;
    end
  end

  // Counter runs XLEN..1 for the iterations; at 0 the sign fix-up is written out
  assign w_iter_done = (r_cnt == '0);

  // Next-state logic
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:       if (w_accept) w_state_next = w_in_state;
      StExec:       w_state_next = StDone;
      StMul, StDiv: if (w_iter_done) w_state_next = StDone;
      StDone:       if (out_ready) w_state_next = StIdle;
      default:      w_state_next = StIdle;
    endcase
  end

  // State register; r_init keeps in_ready low until the first edge after reset release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_init  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_init  <= 1'b1;
    end
  end

  // One shift-add step: low half holds remaining multiplier bits
  assign w_mul_sum  = {1'b0, r_acc[2*XLEN-1:XLEN]} +
                      (r_acc[0] ? {1'b0, r_mag} : {(XLEN+1){1'b0}});
  assign w_mul_next = {w_mul_sum, r_acc[XLEN-1:1]};

  // One restoring step: high half is the partial remainder, low half shifts dividend out
  assign w_rem_sh   = {r_acc[2*XLEN-1:XLEN], r_acc[XLEN-1]};
  assign w_div_ge   = (w_rem_sh >= {1'b0, r_mag});
  assign w_div_sub  = w_rem_sh[XLEN-1:0] - r_mag;
  assign w_div_next = w_div_ge ? {w_div_sub, r_acc[XLEN-2:0], 1'b1}
                               : {w_rem_sh[XLEN-1:0], r_acc[XLEN-2:0], 1'b0};

  // Operand latch at accept and engine iteration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_a          <= '0;
      r_b          <= '0;
      r_mag        <= '0;
      r_acc        <= '0;
      r_cnt        <= '0;
      r_ctrl       <= CtrlAdd;
      r_div_uns    <= 1'b0;
      r_op_illegal <= 1'b0;
      r_a_signed   <= 1'b0;
      r_b_signed   <= 1'b0;
    end else if (w_accept) begin
      r_a          <= src_a;
      r_b          <= src_b;
      r_ctrl       <= w_dec_ctrl;
      r_div_uns    <= w_dec_div_uns;
      r_op_illegal <= w_dec_illegal;
      r_a_signed   <= w_a_signed;
      r_b_signed   <= w_b_signed;
      r_cnt        <= CNT_W'(XLEN);
      if (is_div_op(w_dec_ctrl)) begin
        r_acc <= {{XLEN{1'b0}}, f_mag(src_a, w_a_signed)};
        r_mag <= f_mag(src_b, w_b_signed);
      end else begin
        r_acc <= {{XLEN{1'b0}}, f_mag(src_b, w_b_signed)};
        r_mag <= f_mag(src_a, w_a_signed);
      end
    end else if (((r_state == StMul) || (r_state == StDiv)) && !w_iter_done) begin
      r_acc <= (r_state == StMul) ? w_mul_next : w_div_next;
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign w_shamt    = r_b[SH_W-1:0];
  assign w_div_case = f_div_case(r_a, r_b, r_div_uns);

  // Single-cycle results: base ops, illegal, and mul/div fast paths
  always_comb begin
    w_exec_res = '0;
    if (!r_op_illegal) begin
      unique case (r_ctrl)
        CtrlAdd:  w_exec_res = r_a + r_b;
        CtrlSub:  w_exec_res = r_a - r_b;
        CtrlSll:  w_exec_res = r_a << w_shamt;
        CtrlSlt:  w_exec_res = {{(XLEN-1){1'b0}}, $signed(r_a) < $signed(r_b)};
        CtrlSltu: w_exec_res = {{(XLEN-1){1'b0}}, r_a < r_b};
        CtrlXor:  w_exec_res = r_a ^ r_b;
        CtrlSrl:  w_exec_res = r_a >> w_shamt;
        CtrlSra:  w_exec_res = XLEN'($signed(r_a) >>> w_shamt);
        CtrlOr:   w_exec_res = r_a | r_b;
        CtrlAnd:  w_exec_res = r_a & r_b;
        CtrlDiv: begin
          unique case (w_div_case)
            DivByZero:   w_exec_res = '1;
            DivOverflow: w_exec_res = r_a;
            default:     w_exec_res = '0;
          endcase
        end
        CtrlRem:  w_exec_res = (w_div_case == DivOverflow) ? '0 : r_a;
        default:  w_exec_res = '0; // mul early-out: an operand was zero
      endcase
    end
  end

  // Sign fix-up on engine completion
  assign w_neg  = (r_a_signed && r_a[XLEN-1]) ^ (r_b_signed && r_b[XLEN-1]);
  assign w_prod = w_neg ? (~r_acc + 1'b1) : r_acc;
  assign w_quo  = w_neg ? (~r_acc[XLEN-1:0] + 1'b1) : r_acc[XLEN-1:0];
  assign w_rem  = (r_a_signed && r_a[XLEN-1]) ? (~r_acc[2*XLEN-1:XLEN] + 1'b1)
                                              : r_acc[2*XLEN-1:XLEN];

  // Pick the engine result half/quantity for the decoded op
  always_comb begin
    w_fin_res = '0;
    unique case (r_ctrl)
      CtrlMul:                          w_fin_res = w_prod[XLEN-1:0];
      CtrlMulh, CtrlMulhsu, CtrlMulhu:  w_fin_res = w_prod[2*XLEN-1:XLEN];
      CtrlDiv:                          w_fin_res = w_quo;
      CtrlRem:                          w_fin_res = w_rem;
      default:                          w_fin_res = '0;
    endcase
  end

  // Result registers, written only when entering DONE so they hold while out_valid
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_result  <= '0;
      r_zero    <= 1'b0;
      r_illegal <= 1'b0;
    end else if (r_state == StExec) begin
      r_result  <= w_exec_res;
      r_zero    <= (w_exec_res == '0);
      r_illegal <= r_op_illegal;
    end else if (((r_state == StMul) || (r_state == StDiv)) && w_iter_done) begin
      r_result  <= w_fin_res;
      r_zero    <= (w_fin_res == '0);
      r_illegal <= 1'b0;
    end
  end

  assign in_ready  = r_init && (r_state == StIdle);
  assign out_valid = (r_state == StDone);
  assign result    = r_result;
  assign zero      = r_zero;
  assign illegal   = r_illegal;

endmodule

// File: tb/tb_alu_exec_unit.sv
// Self-checking bench for alu_exec_unit (XLEN=32): directed cases plus randomized ops
// checked against a plain-arithmetic reference model.
module tb_alu_exec_unit;

`ifdef ALU_EARLY_OUT_EN
  localparam bit Early = 1'b1;
`else
  localparam bit Early = 1'b0;
`endif

  logic        clk, rst_n, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  alu_op;
  logic [2:0]  funct3;
  logic        op_5, funct7_5, funct7_0, zero, illegal;
  logic [31:0] src_a, src_b, result;

  int n_checks = 0;
  int n_pass   = 0;

  logic        mon_armed = 1'b0;
  logic [31:0] exp_res;
  logic        exp_zero, exp_ill;

  alu_exec_unit #(.XLEN(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .alu_op    (alu_op),
    .funct3    (funct3),
    .op_5      (op_5),
    .funct7_5  (funct7_5),
    .funct7_0  (funct7_0),
    .src_a     (src_a),
    .src_b     (src_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
  endtask

  // Reference: result, illegal flag and accept->out_valid latency from the op rules
  task automatic model(input logic [1:0] aop, input logic [2:0] f3, input logic o5, f75, f70,
                       input logic [31:0] a, b, output logic [31:0] r, output logic ill,
                       output int lat);
    longint sa, sb, sp, aa, ab;
    logic [63:0] ua, ub, up;
    logic [31:0] q, rm;
    int sh;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    aa = (sa < 0) ? -sa : sa;
    ab = (sb < 0) ? -sb : sb;
    sh = int'(b[4:0]);
    r = '0; ill = 1'b0; lat = 1; q = '0; rm = '0;
    case (aop)
      2'b00: r = a + b;
      2'b01: r = a - b;
      2'b11: ill = 1'b1;
      default: begin
        if (o5 && f70) begin
          lat = 33;
          case (f3)
            3'd0: begin sp = sa * sb; r = sp[31:0]; end
            3'd1: begin sp = sa * sb; r = sp[63:32]; end
            3'd2: begin sp = sa * longint'(ub); r = sp[63:32]; end
            3'd3: begin up = ua * ub; r = up[63:32]; end
            3'd4, 3'd6: begin
              if (b == 0) begin q = '1; rm = a; lat = 1; end
              else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                q = a; rm = '0; lat = 1;
              end else begin
                sp = sa / sb; q = sp[31:0];
                sp = sa % sb; rm = sp[31:0];
                if (Early && aa < ab) lat = 1;
              end
              r = (f3 == 3'd4) ? q : rm;
            end
            default: begin
              if (b == 0) begin q = '1; rm = a; lat = 1; end
              else begin
                q = a / b; rm = a % b;
                if (Early && a < b) lat = 1;
              end
              r = (f3 == 3'd5) ? q : rm;
            end
          endcase
          if (f3 < 3'd4 && Early && (a == 0 || b == 0)) lat = 1;
        end else begin
          case (f3)
            3'd0: r = (o5 && f75) ? a - b : a + b;
            3'd1: r = a << sh;
            3'd2: r = (sa < sb) ? 32'd1 : 32'd0;
            3'd3: r = (a < b) ? 32'd1 : 32'd0;
            3'd4: r = a ^ b;
            3'd5: begin
              if (f75) begin sp = sa >>> sh; r = sp[31:0]; end
              else r = a >> sh;
            end
            3'd6: r = a | b;
            default: r = a & b;
          endcase
        end
      end
    endcase
  endtask

  // Compare process: every cycle a result is presented
  always @(negedge clk) begin
    if (mon_armed && rst_n && out_valid) begin
      check("mon_result", result, exp_res);
      check("mon_zero", {31'd0, zero}, {31'd0, exp_zero});
      check("mon_illegal", {31'd0, illegal}, {31'd0, exp_ill});
    end
  end

  // Issue one op, check latency and backpressure behaviour; returns result and latency
  task automatic do_op(input logic [1:0] aop, input logic [2:0] f3, input logic o5, f75, f70,
                       input logic [31:0] a, b, input int hold,
                       output logic [31:0] got, output int lat);
    logic [31:0] er;
    logic        eill;
    int          elat, n, w;
    model(aop, f3, o5, f75, f70, a, b, er, eill, elat);
    exp_res = er; exp_ill = eill; exp_zero = (er == 32'd0);
    alu_op = aop; funct3 = f3; op_5 = o5; funct7_5 = f75; funct7_0 = f70;
    src_a = a; src_b = b; in_valid = 1'b1; out_ready = (hold == 0);
    w = 0;
    while (!in_ready && w < 200) begin @(posedge clk); #1; w++; end
    check("accept_wait", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    // Operand/field changes after accept must not matter
    src_a = $urandom; src_b = $urandom; funct3 = 3'($urandom); alu_op = 2'($urandom);
    op_5 = 1'($urandom); funct7_0 = 1'($urandom); funct7_5 = 1'($urandom);
    n = 0;
    while (!out_valid && n < 100) begin @(posedge clk); #1; n++; end
    check("latency", 32'(n), 32'(elat));
    got = result;
    lat = n;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", {31'd0, out_valid}, 32'd1);
      check("hold_ready", {31'd0, in_ready}, 32'd0);
      check("hold_result", result, got);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("release_valid", {31'd0, out_valid}, 32'd0);
    check("release_ready", {31'd0, in_ready}, 32'd1);
  endtask

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 6))
      0: return 32'd0;
      1: return 32'd1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] mr, got;
    logic        mi;
    int          ml, lat, w;
    logic [1:0]  raop;

    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    alu_op = 2'b00; funct3 = 3'd0; op_5 = 1'b0; funct7_5 = 1'b0; funct7_0 = 1'b0;
    src_a = '0; src_b = '0;

    // Pin the reference model with hand-computed values
    model(2'b10, 3'd0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, mr, mi, ml);
    check("model_sub", mr, 32'hFFFF_FFFE);
    model(2'b10, 3'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, mr, mi, ml);
    check("model_mulh", mr, 32'hFFFF_FFFF);
    check("model_mul_lat", 32'(ml), 32'd33);
    model(2'b10, 3'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, mr, mi, ml);
    check("model_mulhu", mr, 32'd2);
    model(2'b10, 3'd6, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, mr, mi, ml);
    check("model_rem", mr, 32'hFFFF_FFFF);
    model(2'b10, 3'd5, 1'b0, 1'b1, 1'b0, 32'h8000_0000, 32'd4, mr, mi, ml);
    check("model_sra", mr, 32'hF800_0000);
    model(2'b10, 3'd2, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, mr, mi, ml);
    check("model_slt", mr, 32'd1);
    model(2'b10, 3'd3, 1'b1, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, mr, mi, ml);
    check("model_sltu", mr, 32'd0);

    // Reset values
    #12;
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_result", result, 32'd0);
    check("rst_zero", {31'd0, zero}, 32'd0);
    check("rst_illegal", {31'd0, illegal}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // Reset in the middle of a multiply
    alu_op = 2'b10; funct3 = 3'd0; op_5 = 1'b1; funct7_0 = 1'b1;
    src_a = 32'hFFFF_FFFF; src_b = 32'd3; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (10) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midmul_rst_valid", {31'd0, out_valid}, 32'd0);
    #10 rst_n = 1'b1;
    @(posedge clk); #1;
    check("midmul_in_ready", {31'd0, in_ready}, 32'd1);
    check("midmul_out_valid", {31'd0, out_valid}, 32'd0);

    // Reset while a result is held under backpressure
    alu_op = 2'b00; src_a = 32'd4; src_b = 32'd5; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 10) begin @(posedge clk); #1; w++; end
    check("held_result", result, 32'd9);
    rst_n = 1'b0;
    #1;
    check("held_rst_valid", {31'd0, out_valid}, 32'd0);
    check("held_rst_result", result, 32'd0);
    #10 rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;

    mon_armed = 1'b1;
    do_op(2'b00, 3'd0, 1'b0, 1'b0, 1'b0, 32'd2, 32'd3, 0, got, lat);
    check("add_2_3", got, 32'd5);

    // Add/sub decode
    do_op(2'b10, 3'd0, 1'b1, 1'b1, 1'b0, 32'd5, 32'd7, 0, got, lat);
    check("dec_sub", got, 32'hFFFF_FFFE);
    check("dec_sub_lat", 32'(lat), 32'd1);
    do_op(2'b10, 3'd0, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, 0, got, lat);
    check("dec_add", got, 32'd12);

    // Multiply
    do_op(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 0, got, lat);
    check("mul", got, 32'hFFFF_FFFD);
    check("mul_lat", 32'(lat), 32'd33);
    do_op(2'b10, 3'd1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 0, got, lat);
    check("mulh", got, 32'hFFFF_FFFF);
    do_op(2'b10, 3'd3, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF, 32'd3, 0, got, lat);
    check("mulhu", got, 32'd2);

    // Divide special cases and a normal signed divide
    do_op(2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 32'd7, 32'd0, 0, got, lat);
    check("div_by0", got, 32'hFFFF_FFFF);
    check("div_by0_lat", 32'(lat), 32'd1);
    do_op(2'b10, 3'd6, 1'b1, 1'b0, 1'b1, 32'd7, 32'd0, 0, got, lat);
    check("rem_by0", got, 32'd7);
    do_op(2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, got, lat);
    check("div_ovf", got, 32'h8000_0000);
    check("div_ovf_lat", 32'(lat), 32'd1);
    do_op(2'b10, 3'd6, 1'b1, 1'b0, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, got, lat);
    check("rem_ovf", got, 32'd0);
    do_op(2'b10, 3'd4, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, got, lat);
    check("div_neg", got, 32'hFFFF_FFFD);
    check("div_neg_lat", 32'(lat), 32'd33);
    do_op(2'b10, 3'd6, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFF9, 32'd2, 0, got, lat);
    check("rem_neg", got, 32'hFFFF_FFFF);

    // Backpressure for five cycles
    do_op(2'b10, 3'd4, 1'b0, 1'b0, 1'b0, 32'h0F0F_0000, 32'h00FF_00FF, 5, got, lat);
    check("bp_xor", got, 32'h0FF0_00FF);

    // Early-out and illegal
    do_op(2'b10, 3'd0, 1'b1, 1'b0, 1'b1, 32'd0, 32'd9, 0, got, lat);
    check("mul_zero", got, 32'd0);
    check("mul_zero_lat", 32'(lat), Early ? 32'd1 : 32'd33);
    do_op(2'b11, 3'd0, 1'b0, 1'b0, 1'b0, 32'd3, 32'd4, 0, got, lat);
    check("illegal_result", got, 32'd0);
    check("illegal_flag", {31'd0, illegal}, 32'd1);
    check("illegal_zero", {31'd0, zero}, 32'd1);

    // Randomized ops
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0: raop = 2'b00;
        1: raop = 2'b01;
        2: raop = 2'b11;
        default: raop = 2'b10;
      endcase
      do_op(raop, 3'($urandom), 1'($urandom), 1'($urandom),
            ($urandom_range(0, 9) < 6) ? 1'b1 : 1'b0,
            rand_operand(), rand_operand(), int'($urandom_range(0, 3)), got, lat);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "simulation timeout");
  end

endmodule
